// File: rtl/ddr2_bank_tracker.sv
// ddr2_bank_tracker
//   Passive protocol tracker on the DDR2 controller-to-DRAM command bus.
//   Decodes ACT/RD/WR/PRE/PREA, tracks per-bank open state, open row and
//   the tRCD/tRAS/tRP timers for 4 banks. One registered record is emitted
//   per decoded command, carrying a single prioritised protocol-error code.
//
//   Optional feature: define DDR2_TRK_STATS_EN to add saturating per-type
//   command counters (act_count, rd_count, wr_count, pre_count).
//
// Ports
//   ck                    clock, all logic on posedge
//   reset                 synchronous active-high reset
//   cke                   clock enable from controller
//   addr[12:0]            row (ACT), column [9:0] (RD/WR), [10]=all (PRE)
//   ba[1:0]               bank address
//   cs_n/ras_n/cas_n/we_n command strobes, active low
//   txn_valid             one-cycle record strobe
//   txn_type[2:0]         1=ACT 2=RD 3=WR 4=PRE 5=PREA
//   txn_bank[1:0]         bank of the command
//   txn_row[12:0]         ACT: addr; RD/WR/PRE: open row (0 if closed); PREA: 0
//   txn_col[9:0]          addr[9:0] for RD/WR, else 0
//   txn_err               command violated protocol
//   err_code[2:0]         0 none,1 ACT_OPEN,2 TRP,3 RW_CLOSED,4 TRCD,5 TRAS
//   err_count[15:0]       saturating count of errored commands
//   open_mask[3:0]        live bank ACTIVE state
//   act/rd/wr/pre_count   (DDR2_TRK_STATS_EN only) saturating type counters
module ddr2_bank_tracker #(
   parameter int T_RCD = 3,
   parameter int T_RAS = 8,
   parameter int T_RP  = 3
) (
   input  logic        ck,
   input  logic        reset,
   input  logic        cke,
   input  logic [12:0] addr,
   input  logic [1:0]  ba,
   input  logic        cs_n,
   input  logic        ras_n,
   input  logic        cas_n,
   input  logic        we_n,
   output logic        txn_valid,
   output logic [2:0]  txn_type,
   output logic [1:0]  txn_bank,
   output logic [12:0] txn_row,
   output logic [9:0]  txn_col,
   output logic        txn_err,
   output logic [2:0]  err_code,
   output logic [15:0] err_count,
   output logic [3:0]  open_mask
`ifdef DDR2_TRK_STATS_EN
   ,
   output logic [15:0] act_count,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count,
   output logic [15:0] pre_count
`endif
);

   localparam logic [3:0] RCD_LD = 4'(T_RCD - 1);
   localparam logic [3:0] RAS_LD = 4'(T_RAS - 1);
   localparam logic [3:0] RP_LD  = 4'(T_RP - 1);

   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_PRE = 4'b0010;

   // per-bank state
   logic              r_cke_prev;
   logic [3:0]        r_active;
   logic [3:0][12:0]  r_row;
   logic [3:0][3:0]   r_rcd_cnt;
   logic [3:0][3:0]   r_ras_cnt;
   logic [3:0][3:0]   r_rp_cnt;

   // record registers
   logic        r_txn_valid;
   logic [2:0]  r_txn_type;
   logic [1:0]  r_txn_bank;
   logic [12:0] r_txn_row;
   logic [9:0]  r_txn_col;
   logic        r_txn_err;
   logic [2:0]  r_err_code;
   logic [15:0] r_err_count;

   // decode
   logic [3:0]  w_cmd;
   logic        w_dec;
   logic        w_act, w_rd, w_wr, w_pre, w_prea, w_rec;
   logic [3:0]  w_act_b;
   logic [3:0]  w_pre_b;
   logic [3:0]  w_ras_busy;
   logic [2:0]  w_type;
   logic [2:0]  w_code;
   logic [12:0] w_row;
   logic [9:0]  w_col;

   function automatic logic [3:0] dec_sat(input logic [3:0] v);
      return (v == 4'd0) ? 4'd0 : v - 4'd1;
   endfunction

   always_comb begin
      w_cmd  = {cs_n, ras_n, cas_n, we_n};
      // both the current and previous cke must be high for the DRAM to see it
      w_dec  = !reset && cke && r_cke_prev;
      w_act  = w_dec && (w_cmd == CMD_ACT);
      w_rd   = w_dec && (w_cmd == CMD_RD);
      w_wr   = w_dec && (w_cmd == CMD_WR);
      w_pre  = w_dec && (w_cmd == CMD_PRE) && !addr[10];
      w_prea = w_dec && (w_cmd == CMD_PRE) &&  addr[10];
      w_rec  = w_act || w_rd || w_wr || w_pre || w_prea;

      w_act_b    = '0;
      w_pre_b    = '0;
      w_ras_busy = '0;
      for (int b = 0; b < 4; b++) begin
         w_act_b[b]    = w_act && (ba == 2'(b));
         w_pre_b[b]    = (w_pre && (ba == 2'(b))) || w_prea;
         w_ras_busy[b] = r_active[b] && (r_rcd_cnt[b] == r_rcd_cnt[b]) && (r_ras_cnt[b] != 4'd0);
      end
   end

   // record contents and single prioritised error code
   always_comb begin
      w_type = 3'd0;
      w_code = 3'd0;
      w_row  = 13'd0;
      w_col  = 10'd0;
      if (w_act) begin
         w_type = 3'd1;
         w_row  = addr;
         if (r_active[ba])
            w_code = 3'd1;
         else if (r_rp_cnt[ba] != 4'd0)
            w_code = 3'd2;
      end else if (w_rd || w_wr) begin
         w_type = w_rd ? 3'd2 : 3'd3;
         w_col  = addr[9:0];
         if (!r_active[ba])
            w_code = 3'd3;
         else begin
            w_row = r_row[ba];
            if (r_rcd_cnt[ba] != 4'd0)
               w_code = 3'd4;
         end
      end else if (w_pre) begin
         w_type = 3'd4;
         if (r_active[ba]) begin
            w_row = r_row[ba];
            if (w_ras_busy[ba])
               w_code = 3'd5;
         end
      end else if (w_prea) begin
         w_type = 3'd5;
         if (|w_ras_busy)
            w_code = 3'd5;
      end
   end

   // bank state: state follows the issued command even when it is errored,
   // and a load by a command takes precedence over that cycle's decrement
   always_ff @(posedge ck) begin
      if (reset) begin
         r_active  <= '0;
         r_row     <= '0;
         r_rcd_cnt <= '0;
         r_ras_cnt <= '0;
         r_rp_cnt  <= '0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (w_act_b[b]) begin
               r_active[b]  <= 1'b1;
               r_row[b]     <= addr;
               r_rcd_cnt[b] <= RCD_LD;
               r_ras_cnt[b] <= RAS_LD;
            end else begin
               r_rcd_cnt[b] <= dec_sat(r_rcd_cnt[b]);
               r_ras_cnt[b] <= dec_sat(r_ras_cnt[b]);
            end
            // PRE to an idle bank is a legal no-op
            if (w_pre_b[b] && r_active[b]) begin
               r_active[b] <= 1'b0;
               r_rp_cnt[b] <= RP_LD;
            end else begin
               r_rp_cnt[b] <= dec_sat(r_rp_cnt[b]);
            end
         end
      end
   end

   always_ff @(posedge ck) begin
      if (reset) begin
         r_cke_prev  <= 1'b0;
         r_txn_valid <= 1'b0;
         r_txn_type  <= '0;
         r_txn_bank  <= '0;
         r_txn_row   <= '0;
         r_txn_col   <= '0;
         r_txn_err   <= 1'b0;
         r_err_code  <= '0;
         r_err_count <= '0;
      end else begin
         r_cke_prev  <= cke;
         r_txn_valid <= w_rec;
         if (w_rec) begin
            r_txn_type <= w_type;
            r_txn_bank <= ba;
            r_txn_row  <= w_row;
            r_txn_col  <= w_col;
            r_txn_err  <= (w_code != 3'd0);
            r_err_code <= w_code;
            if ((w_code != 3'd0) && (r_err_count != 16'hFFFF))
               r_err_count <= r_err_count + 16'd1;
         end
      end
   end

   assign txn_valid = r_txn_valid;
   assign txn_type  = r_txn_type;
   assign txn_bank  = r_txn_bank;
   assign txn_row   = r_txn_row;
   assign txn_col   = r_txn_col;
   assign txn_err   = r_txn_err;
   assign err_code  = r_err_code;
   assign err_count = r_err_count;
   assign open_mask = r_active;

`ifdef DDR2_TRK_STATS_EN
   logic [15:0] r_act_count, r_rd_count, r_wr_count, r_pre_count;

   always_ff @(posedge ck) begin
      if (reset) begin
         r_act_count <= '0;
         r_rd_count  <= '0;
         r_wr_count  <= '0;
         r_pre_count <= '0;
      end else begin
         if (w_act && (r_act_count != 16'hFFFF))
            r_act_count <= r_act_count + 16'd1;
         if (w_rd && (r_rd_count != 16'hFFFF))
            r_rd_count <= r_rd_count + 16'd1;
         if (w_wr && (r_wr_count != 16'hFFFF))
            r_wr_count <= r_wr_count + 16'd1;
         if ((w_pre || w_prea) && (r_pre_count != 16'hFFFF))
            r_pre_count <= r_pre_count + 16'd1;
      end
   end

   assign act_count = r_act_count;
   assign rd_count  = r_rd_count;
   assign wr_count  = r_wr_count;
   assign pre_count = r_pre_count;
`endif

endmodule

// File: doc/ddr2_bank_tracker.md
Name: ddr2_bank_tracker

Overview:
- Synthesizable protocol tracker on the DDR2 controller-to-DRAM command bus, in parallel with the interface monitor.
- Decodes each command and keeps per-bank open/closed state, the open row and the tRCD/tRAS/tRP timers for 4 banks.
- Emits one registered transaction record per decoded command, with a protocol-error flag.
- Consumers are the scoreboard and the error-logging logic.

Parameters:
- T_RCD, 3, min cycles ACTIVATE to READ/WRITE, same bank (1..15)
- T_RAS, 8, min cycles ACTIVATE to PRECHARGE, same bank (1..15)
- T_RP, 3, min cycles PRECHARGE to ACTIVATE, same bank (1..15)

Ports:
- ck  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- cke  in  1  clock enable from controller
- addr  in  13  row address (ACT), column address in [9:0] (RD/WR), addr[10] = precharge-all (PRE)
- ba  in  2  bank address
- cs_n, ras_n, cas_n, we_n  in  1 each  command strobes, active-low
- txn_valid  out  1  one-cycle pulse, record valid
- txn_type  out  3  1=ACT, 2=RD, 3=WR, 4=PRE, 5=PREA
- txn_bank  out  2  bank of the command
- txn_row  out  13  ACT: addr; RD/WR/PRE: tracked open row of bank (0 if closed); PREA: 0
- txn_col  out  10  addr[9:0] for RD/WR, else 0
- txn_err  out  1  command violated protocol
- err_code  out  3  0=none, 1=ACT_OPEN, 2=TRP, 3=RW_CLOSED, 4=TRCD, 5=TRAS
- err_count  out  16  saturating count of errored commands
- open_mask  out  4  bit b = bank b ACTIVE (live state)

Behaviour:
- Clocking and reset:
  - Single clock ck.
  - Reset is synchronous, active-high. It sets all outputs to 0, all banks IDLE, all timers 0, open rows 0, and cke_prev 0.
  - Reset asserted mid-burst or mid-timer discards all state, and the command on the bus in that cycle is ignored.
- Command qualification:
  - cke_prev is registered from cke every cycle.
  - A command is decoded only when !reset && cke && cke_prev.
  - Encoding {cs_n,ras_n,cas_n,we_n}: 0011 ACT, 0101 RD, 0100 WR, 0010 PRE (addr[10]=1 means PREA).
  - All other codes (NOP 0111, deselect, REFRESH, MRS, etc.) produce no record and leave state unchanged.
- Per-bank state: IDLE/ACTIVE plus 4-bit rcd_cnt, ras_cnt, rp_cnt, and row[12:0].
  - Each counter decrements by 1 per cycle and saturates at 0.
  - A command loads a counter with T-1. The target command is legal when the counter reads 0, i.e. N cycles after the source command with N = T.
- ACT to bank b:
  - Error if b is ACTIVE (ACT_OPEN); else error if rp_cnt!=0 (TRP).
  - Always sets b ACTIVE, row=addr, rcd_cnt=T_RCD-1, ras_cnt=T_RAS-1.
- RD/WR to bank b:
  - Error if b is IDLE (RW_CLOSED); else error if rcd_cnt!=0 (TRCD).
  - No state change.
- PRE to bank b:
  - If b is ACTIVE: error if ras_cnt!=0 (TRAS). b goes IDLE and rp_cnt=T_RP-1.
  - If b is already IDLE: legal, no state change.
- PREA:
  - Applies the PRE rule to every ACTIVE bank.
  - TRAS error if any ACTIVE bank has ras_cnt!=0.
  - txn_bank = ba.
- Error handling:
  - Only one code is reported per command, by the priority order listed above.
  - Bank state always follows the issued command, even when errored, so tracking matches DRAM intent.
- Record timing:
  - Record fields are registered; latency is 1 cycle from the command edge.
  - txn_valid is low in every cycle with no decoded command.
  - Other record fields hold their last value.
- err_count increments on each txn_err and saturates at 0xFFFF.
- open_mask reflects bank state after the current cycle's update (registered).
- Same-cycle events: a counter load by a command overrides that cycle's decrement.

Optional Feature:
- Macro DDR2_TRK_STATS_EN.
- When defined, the block adds outputs act_count, rd_count, wr_count, pre_count (16 bits each, saturating, cleared by reset). Each increments on every record of its type; PREA counts as pre.
- When undefined, these ports and their logic do not exist.

Test Plan:
- ACT b1 row 0x0A5, NOPs, RD b1 col 0x010 exactly 3 cycles after ACT:
  - ACT record: type 1, row 0x0A5, err 0.
  - RD record: type 2, bank 1, row 0x0A5, col 0x010, err 0.
  - open_mask=0010.
- ACT b0, then WR b0 2 cycles later -> WR record with err_code 4, err_count=1.
- RD b2 while all banks IDLE -> err_code 3, open_mask unchanged 0000.
- ACT b3, PRE b3 after 5 cycles -> err_code 5, b3 IDLE. ACT b3 1 cycle later -> err_code 2. ACT b3 again -> err_code 1.
- ACT b0 and b2, wait 8 cycles, PRE with addr[10]=1 -> type 5, err 0, open_mask=0000.
- Reset pulse one cycle after ACT b1 -> open_mask=0 and no record.
- cke high for only one cycle with an ACT on the bus -> ignored, no txn_valid.
